// File: rtl/secventiator_cursa.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : secventiator_cursa                                              |
// | Brief    : race sequencer; debounced lap counting, race FSM, motor gating  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module secventiator_cursa #(
  parameter int DEBOUNCE_CYC    = 50000,
  parameter int BLANK_CYC       = 25000000,
  parameter int START_DELAY_CYC = 50000000,
  parameter int LAPS_C1         = 1,
  parameter int LAPS_C2         = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  circuit,
  input  logic        senzor_1,
  input  logic        senzor_5,
  input  logic [1:0]  dir_in_A,
  input  logic [1:0]  dir_in_B,
  input  logic [11:0] dc_in_A,
  input  logic [11:0] dc_in_B,
  output logic [1:0]  directie_driverA,
  output logic [1:0]  directie_driverB,
  output logic [11:0] factor_dc_driverA,
  output logic [11:0] factor_dc_driverB,
  output logic [7:0]  count_ture,
  output logic [2:0]  stare,
  output logic        stop_cursa,
  output logic        lap_pulse
);

  localparam int c_db_w      = $clog2(DEBOUNCE_CYC + 1);
  localparam int c_tmr_max   = (START_DELAY_CYC > BLANK_CYC) ? START_DELAY_CYC : BLANK_CYC;
  localparam int c_tmr_w     = $clog2(c_tmr_max + 1);
  localparam logic [c_db_w-1:0]  c_db_full   = c_db_w'(DEBOUNCE_CYC);
  localparam logic [c_db_w-1:0]  c_db_last   = c_db_w'(DEBOUNCE_CYC - 1);
  localparam logic [c_tmr_w-1:0] c_start_end = c_tmr_w'(START_DELAY_CYC - 1);
  localparam logic [c_tmr_w-1:0] c_blank_end = c_tmr_w'(BLANK_CYC - 1);
  localparam logic [7:0]         c_laps_c1   = 8'(LAPS_C1);
  localparam logic [7:0]         c_laps_c2   = 8'(LAPS_C2);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_RUN   = 3'd2,
    ST_BLANK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  logic               r_start_meta, r_start_sync, r_start_prev;
  logic               r_s1_meta, r_s1_sync, r_s5_meta, r_s5_sync;
  logic [c_db_w-1:0]  r_db_cnt;
  logic               r_lap_evt;
  state_t             r_state, w_state_nxt;
  logic [c_tmr_w-1:0] r_timer, w_timer_nxt;
  logic [1:0]         r_circ_q, w_circ_nxt;
  logic [7:0]         w_count_nxt, w_count_inc;
  logic               w_lap_pulse_nxt, w_start_edge, w_finish, w_target, w_motors_on;

  assign w_start_edge = r_start_sync & ~r_start_prev;
  assign w_finish     = r_s1_sync & r_s5_sync;
  assign w_count_inc  = (count_ture == 8'hFF) ? count_ture : count_ture + 8'd1;
  assign w_target     = ((r_circ_q == 2'b01) && (w_count_inc == c_laps_c1)) ||
                        ((r_circ_q == 2'b10) && (w_count_inc == c_laps_c2));
  assign w_motors_on  = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_BLANK);
  assign stare        = r_state;

  // Debounce saturates at full count, so the strobe re-arms only once finish drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_meta <= 1'b0;
      r_start_sync <= 1'b0;
      r_start_prev <= 1'b0;
      r_s1_meta    <= 1'b0;
      r_s1_sync    <= 1'b0;
      r_s5_meta    <= 1'b0;
      r_s5_sync    <= 1'b0;
      r_db_cnt     <= '0;
      r_lap_evt    <= 1'b0;
    end else begin
      r_start_meta <= start;
      r_start_sync <= r_start_meta;
      r_start_prev <= r_start_sync;
      r_s1_meta    <= senzor_1;
      r_s1_sync    <= r_s1_meta;
      r_s5_meta    <= senzor_5;
      r_s5_sync    <= r_s5_meta;
      r_lap_evt    <= w_finish && (r_db_cnt == c_db_last);
      if (!w_finish) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt != c_db_full) begin
        r_db_cnt <= r_db_cnt + c_db_w'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_timer_nxt     = r_timer;
    w_circ_nxt      = r_circ_q;
    w_count_nxt     = count_ture;
    w_lap_pulse_nxt = 1'b0;
    if (circuit == 2'b00) begin
      w_state_nxt = ST_IDLE;
      w_timer_nxt = '0;
      w_count_nxt = 8'd0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start_edge) begin
            w_state_nxt = ST_ARM;
            w_circ_nxt  = circuit;
            w_count_nxt = 8'd0;
            w_timer_nxt = '0;
          end
        end
        ST_ARM: begin
          if (w_start_edge) begin
            w_state_nxt = ST_IDLE;
            w_timer_nxt = '0;
          end else if (r_timer == c_start_end) begin
            w_state_nxt = ST_RUN;
            w_timer_nxt = '0;
          end else begin
            w_timer_nxt = r_timer + c_tmr_w'(1);
          end
        end
        ST_RUN: begin
          if (w_start_edge) begin
            w_state_nxt = ST_IDLE;
          end else if (r_lap_evt) begin
            w_count_nxt     = w_count_inc;
            w_lap_pulse_nxt = 1'b1;
            w_timer_nxt     = '0;
            w_state_nxt     = w_target ? ST_DONE : ST_BLANK;
          end
        end
        ST_BLANK: begin
          if (w_start_edge) begin
            w_state_nxt = ST_IDLE;
            w_timer_nxt = '0;
          end else if (r_timer == c_blank_end) begin
            w_state_nxt = ST_RUN;
            w_timer_nxt = '0;
          end else begin
            w_timer_nxt = r_timer + c_tmr_w'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_timer_nxt = '0;
        end
      endcase
    end
  end

  // Gating follows the next state so motors stop on the same edge the FSM leaves RUN/BLANK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state           <= ST_IDLE;
      r_timer           <= '0;
      r_circ_q          <= 2'b00;
      count_ture        <= 8'd0;
      lap_pulse         <= 1'b0;
      stop_cursa        <= 1'b0;
      directie_driverA  <= 2'b00;
      directie_driverB  <= 2'b00;
      factor_dc_driverA <= 12'h000;
      factor_dc_driverB <= 12'h000;
    end else begin
      r_state           <= w_state_nxt;
      r_timer           <= w_timer_nxt;
      r_circ_q          <= w_circ_nxt;
      count_ture        <= w_count_nxt;
      lap_pulse         <= w_lap_pulse_nxt;
      stop_cursa        <= (w_state_nxt == ST_DONE);
      directie_driverA  <= w_motors_on ? dir_in_A : 2'b00;
      directie_driverB  <= w_motors_on ? dir_in_B : 2'b00;
      factor_dc_driverA <= w_motors_on ? dc_in_A : 12'h000;
      factor_dc_driverB <= w_motors_on ? dc_in_B : 12'h000;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_secventiator_cursa.sv
`default_nettype none
// Bench for secventiator_cursa: vector tables for motor gating, lap scoreboard for race sequences.
module tb_secventiator_cursa;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  circuit = 2'b00;
  logic        senzor_1 = 1'b0, senzor_5 = 1'b0;
  logic [1:0]  dir_in_A = 2'b00, dir_in_B = 2'b00;
  logic [11:0] dc_in_A = 12'h000, dc_in_B = 12'h000;
  logic [1:0]  directie_driverA, directie_driverB;
  logic [11:0] factor_dc_driverA, factor_dc_driverB;
  logic [7:0]  count_ture;
  logic [2:0]  stare;
  logic        stop_cursa, lap_pulse;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  bit track_done = 1'b0;
  bit seen_done = 1'b0;

  secventiator_cursa #(
    .DEBOUNCE_CYC(4), .BLANK_CYC(20), .START_DELAY_CYC(10), .LAPS_C1(1), .LAPS_C2(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .circuit(circuit),
    .senzor_1(senzor_1), .senzor_5(senzor_5),
    .dir_in_A(dir_in_A), .dir_in_B(dir_in_B), .dc_in_A(dc_in_A), .dc_in_B(dc_in_B),
    .directie_driverA(directie_driverA), .directie_driverB(directie_driverB),
    .factor_dc_driverA(factor_dc_driverA), .factor_dc_driverB(factor_dc_driverB),
    .count_ture(count_ture), .stare(stare), .stop_cursa(stop_cursa), .lap_pulse(lap_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  da, db;
    logic [11:0] ca, cb;
    logic [1:0]  eda, edb;
    logic [11:0] eca, ecb;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(4);
    start = 1'b0;
  endtask

  task automatic wait_run();
    for (int i = 0; i < 40 && stare != 3'd2; i++) tick(1);
    chk("reach_run", int'(stare), 2);
  endtask

  task automatic crossing(input int n_high);
    senzor_1 = 1'b1;
    senzor_5 = 1'b1;
    tick(n_high);
    senzor_1 = 1'b0;
    senzor_5 = 1'b0;
  endtask

  task automatic chk_stopped(input string nm);
    chk({nm, "_dirA"}, int'(directie_driverA), 0);
    chk({nm, "_dirB"}, int'(directie_driverB), 0);
    chk({nm, "_dcA"}, int'(factor_dc_driverA), 0);
    chk({nm, "_dcB"}, int'(factor_dc_driverB), 0);
  endtask

  // Lap scoreboard: each counted lap must match the next expected count.
  always begin
    @(posedge clk);
    #1;
    if (seen_done == 1'b0 && track_done && stare == 3'd4) seen_done = 1'b1;
    if (lap_pulse) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL lap_sb: unexpected lap_pulse with count %0d expected none (t=%0t)", count_ture, $time);
      end else begin
        chk("lap_sb_count", int'(count_ture), exp_q.pop_front());
      end
    end
  end

  initial begin
    vec_t idle_tab[4];
    vec_t run_tab[6];
    int   arm_cycles;

    idle_tab[0] = '{2'b01, 2'b10, 12'hFFF, 12'h123, 2'b00, 2'b00, 12'h000, 12'h000};
    idle_tab[1] = '{2'b11, 2'b11, 12'h800, 12'h7FF, 2'b00, 2'b00, 12'h000, 12'h000};
    idle_tab[2] = '{2'b10, 2'b01, 12'h001, 12'hABC, 2'b00, 2'b00, 12'h000, 12'h000};
    idle_tab[3] = '{2'b01, 2'b01, 12'h555, 12'hAAA, 2'b00, 2'b00, 12'h000, 12'h000};
    run_tab[0]  = '{2'b01, 2'b10, 12'h3FF, 12'h200, 2'b01, 2'b10, 12'h3FF, 12'h200};
    run_tab[1]  = '{2'b10, 2'b01, 12'hFFF, 12'h000, 2'b10, 2'b01, 12'hFFF, 12'h000};
    run_tab[2]  = '{2'b11, 2'b00, 12'h001, 12'hFFE, 2'b11, 2'b00, 12'h001, 12'hFFE};
    run_tab[3]  = '{2'b00, 2'b11, 12'h800, 12'h7FF, 2'b00, 2'b11, 12'h800, 12'h7FF};
    run_tab[4]  = '{2'b01, 2'b01, 12'hA5A, 12'h5A5, 2'b01, 2'b01, 12'hA5A, 12'h5A5};
    run_tab[5]  = '{2'b10, 2'b10, 12'h123, 12'h321, 2'b10, 2'b10, 12'h123, 12'h321};

    // Reset values with live requests on the inputs
    dir_in_A = 2'b01; dir_in_B = 2'b10; dc_in_A = 12'hFFF; dc_in_B = 12'h800;
    tick(3);
    chk("rst_stare", int'(stare), 0);
    chk("rst_count", int'(count_ture), 0);
    chk("rst_stop", int'(stop_cursa), 0);
    chk("rst_lap", int'(lap_pulse), 0);
    chk_stopped("rst");
    rst_n = 1'b1;
    tick(2);

    // Gating in IDLE
    for (int i = 0; i < 4; i++) begin
      dir_in_A = idle_tab[i].da; dir_in_B = idle_tab[i].db;
      dc_in_A = idle_tab[i].ca; dc_in_B = idle_tab[i].cb;
      tick(1);
      chk("idle_dirA", int'(directie_driverA), int'(idle_tab[i].eda));
      chk("idle_dirB", int'(directie_driverB), int'(idle_tab[i].edb));
      chk("idle_dcA", int'(factor_dc_driverA), int'(idle_tab[i].eca));
      chk("idle_dcB", int'(factor_dc_driverB), int'(idle_tab[i].ecb));
    end

    // Circuit 10: ARM lasts START_DELAY_CYC clocks
    circuit = 2'b10;
    start = 1'b1;
    arm_cycles = 0;
    for (int i = 0; i < 40 && stare != 3'd2; i++) begin
      tick(1);
      if (stare == 3'd1) arm_cycles++;
    end
    start = 1'b0;
    chk("arm_cycles", arm_cycles, 10);
    chk("arm_to_run", int'(stare), 2);

    // Gating in RUN: outputs echo the previous cycle's requests
    for (int i = 0; i < 6; i++) begin
      dir_in_A = run_tab[i].da; dir_in_B = run_tab[i].db;
      dc_in_A = run_tab[i].ca; dc_in_B = run_tab[i].cb;
      tick(1);
      chk("run_dirA", int'(directie_driverA), int'(run_tab[i].eda));
      chk("run_dirB", int'(directie_driverB), int'(run_tab[i].edb));
      chk("run_dcA", int'(factor_dc_driverA), int'(run_tab[i].eca));
      chk("run_dcB", int'(factor_dc_driverB), int'(run_tab[i].ecb));
    end

    // Three crossings reach the target of 3
    for (int lap = 1; lap <= 3; lap++) begin
      exp_q.push_back(lap);
      crossing(8);
      if (lap == 1) begin
        chk("blank_state", int'(stare), 3);
        chk("blank_dirA", int'(directie_driverA), int'(dir_in_A));
        chk("blank_dcB", int'(factor_dc_driverB), int'(dc_in_B));
      end
      tick(32);
    end
    chk("c10_done_stare", int'(stare), 4);
    chk("c10_done_stop", int'(stop_cursa), 1);
    chk("c10_done_count", int'(count_ture), 3);
    chk_stopped("c10_done");

    // New race from DONE clears the count; short and glitchy finishes are rejected
    pulse_start();
    chk("restart_stare", int'(stare), 1);
    chk("restart_count", int'(count_ture), 0);
    wait_run();
    crossing(3);
    tick(10);
    crossing(2);
    tick(1);
    crossing(2);
    tick(10);
    chk("glitch_count", int'(count_ture), 0);
    exp_q.push_back(1);
    crossing(60);
    tick(10);
    chk("long_count", int'(count_ture), 1);
    chk("long_stare", int'(stare), 2);

    // Abort in RUN keeps the count
    pulse_start();
    chk("abort_stare", int'(stare), 0);
    chk("abort_count", int'(count_ture), 1);
    chk_stopped("abort");
    circuit = 2'b00;
    tick(1);
    chk("clear_count", int'(count_ture), 0);

    // Circuit 01: single lap ends the race
    circuit = 2'b01;
    pulse_start();
    wait_run();
    exp_q.push_back(1);
    crossing(8);
    tick(5);
    chk("c01_stare", int'(stare), 4);
    chk("c01_count", int'(count_ture), 1);

    // Circuit 00 on the same clock the lap strobe reaches the FSM
    circuit = 2'b10;
    pulse_start();
    wait_run();
    exp_q.push_back(1);
    crossing(8);
    tick(32);
    senzor_1 = 1'b1; senzor_5 = 1'b1;
    tick(6);
    circuit = 2'b00;
    tick(1);
    chk("clr_lap_stare", int'(stare), 0);
    chk("clr_lap_count", int'(count_ture), 0);
    chk("clr_lap_pulse", int'(lap_pulse), 0);
    senzor_1 = 1'b0; senzor_5 = 1'b0;
    tick(5);

    // Asynchronous reset during BLANK
    circuit = 2'b10;
    pulse_start();
    wait_run();
    dir_in_A = 2'b10; dir_in_B = 2'b01; dc_in_A = 12'h7AB; dc_in_B = 12'h456;
    exp_q.push_back(1);
    crossing(8);
    tick(32);
    exp_q.push_back(2);
    crossing(8);
    chk("prerst_stare", int'(stare), 3);
    chk("prerst_count", int'(count_ture), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_stare", int'(stare), 0);
    chk("arst_count", int'(count_ture), 0);
    chk_stopped("arst");
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("postrst_stare", int'(stare), 0);

    // Circuit 11: count saturates and DONE is never entered
    circuit = 2'b11;
    pulse_start();
    wait_run();
    track_done = 1'b1;
    for (int i = 0; i < 300; i++) begin
      exp_q.push_back((i + 1 > 255) ? 255 : i + 1);
      crossing(8);
      tick(32);
    end
    track_done = 1'b0;
    chk("c11_count", int'(count_ture), 255);
    chk("c11_never_done", int'(seen_done), 0);
    chk("c11_stare", int'(stare), 2);

    tick(5);
    chk("lap_sb_pending", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
